echo_ranger: RTL and testbench

Ultrasonic ranging front end for the parking-distance display. It fires a trigger pulse at the sensor and times the returned echo pulse. It converts the echo width to centimetres as four BCD digits without a divider, by counting a per-centimetre prescaler into a cascaded BCD counter. Its `digit0..digit3` outputs feed the display multiplexer directly, and its status outputs go to the processor/LEDs, making it the producing end of the digit interface.

---
 rtl/ranger_pkg.sv | 26 ++
 rtl/bcd_counter4.sv | 60 ++++++
 rtl/echo_ranger.sv | 209 ++++++++++++++++++++
 tb/tb_echo_ranger.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// ranger_pkg: shared types and constants for the echo_ranger block.
//   state_t  - measurement FSM states
//   bcd_t    - one BCD digit
//   BCD_SAT  - largest BCD digit, also the "no reading" fill value
//   bcd_inc  - single-digit BCD increment with wrap 9 -> 0
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        DONE_OK   = 3'd4,
        DONE_BAD  = 3'd5,
        HOLD      = 3'd6
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_SAT = 4'd9;

    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d == BCD_SAT) ? bcd_t'(0) : bcd_t'(d + 4'd1);
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit cascaded BCD up-counter used as the centimetre
// accumulator.
//   clk, reset    - clock, asynchronous active-low reset
//   clear         - synchronous clear to 0000
//   inc           - add one (ignored while clear is high)
//   d0..d3        - units, tens, hundreds, thousands
//   next_exceeds  - high when one more increment would pass MAX_CM
module bcd_counter4
    import ranger_pkg::*;
#(
    parameter int MAX_CM = 400
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output bcd_t d0,
    output bcd_t d1,
    output bcd_t d2,
    output bcd_t d3,
    output logic next_exceeds
);

    // MAX_CM split into BCD at elaboration. Packed BCD orders the same way
    // as the numbers it encodes, so a plain 16-bit compare works.
    localparam logic [15:0] MAX_BCD = {bcd_t'((MAX_CM / 1000) % 10),
                                       bcd_t'((MAX_CM / 100) % 10),
                                       bcd_t'((MAX_CM / 10) % 10),
                                       bcd_t'(MAX_CM % 10)};

    logic c0, c1, c2;

    // value + 1 > MAX_CM  <=>  value >= MAX_CM
    assign next_exceeds = ({d3, d2, d1, d0} >= MAX_BCD);

    // Ripple carries: a digit advances when every lower digit is at 9.
    assign c0 = inc & (d0 == BCD_SAT);
    assign c1 = c0  & (d1 == BCD_SAT);
    assign c2 = c1  & (d2 == BCD_SAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (clear) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else begin
            if (inc) d0 <= bcd_inc(d0);
            if (c0)  d1 <= bcd_inc(d1);
            if (c1)  d2 <= bcd_inc(d2);
            if (c2)  d3 <= bcd_inc(d3);
        end
    end

endmodule

// File: rtl/echo_ranger.sv
// echo_ranger: ultrasonic ranging front end. Fires a trigger pulse, times the
// echo width in whole centimetres via a per-cm prescaler feeding a BCD
// counter, and presents the result as four BCD digits.
//   clk, reset      - clock, asynchronous active-low reset
//   enable          - run measurements back-to-back while high
//   echo            - raw asynchronous sensor echo
//   trig            - sensor trigger pulse
//   digit0..digit3  - result, units .. thousands (9999 = no reading)
//   valid           - one-cycle strobe when the digits update
//   no_echo         - last result was a timeout or out of range
//   busy            - FSM not in IDLE
//   dbg_state       - current FSM state
//
// Handshake: valid is a single-cycle strobe with no back-pressure; the digits
// and no_echo change on the same edge that raises valid and then hold until
// the next strobe, so a consumer may sample them at any time.
module echo_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES   = 500,
    parameter int CYCLES_PER_CM = 2900,
    parameter int MAX_CM        = 400,
    parameter int WAIT_TIMEOUT  = 1_500_000,
    parameter int PERIOD_CYCLES = 3_000_000
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   enable,
    input  logic   echo,
    output logic   trig,
    output bcd_t   digit0,
    output bcd_t   digit1,
    output bcd_t   digit2,
    output bcd_t   digit3,
    output logic   valid,
    output logic   no_echo,
    output logic   busy,
    output state_t dbg_state
);

    localparam int PHASE_MAX = (TRIG_CYCLES > WAIT_TIMEOUT) ? TRIG_CYCLES : WAIT_TIMEOUT;
    localparam int PHW = $clog2(PHASE_MAX + 1);
    localparam int PRW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;
    localparam int PDW = $clog2(PERIOD_CYCLES + 1);

    localparam logic [PHW-1:0] TRIG_LAST   = PHW'(TRIG_CYCLES - 1);
    localparam logic [PHW-1:0] WAIT_LAST   = PHW'(WAIT_TIMEOUT - 1);
    localparam logic [PRW-1:0] PRESC_LAST  = PRW'(CYCLES_PER_CM - 1);
    localparam logic [PDW-1:0] PERIOD_LAST = PDW'(PERIOD_CYCLES - 1);
    localparam logic [PDW-1:0] PERIOD_SAT  = PDW'(PERIOD_CYCLES);

    state_t         state, next_state;
    logic           echo_meta, echo_s, echo_prev;
    logic           rise, fall;
    logic [PHW-1:0] phase_cnt;
    logic [PRW-1:0] presc;
    logic [PDW-1:0] period_cnt;
    logic           presc_wrap, period_done;
    logic           work_clear, work_inc, work_exceeds;
    bcd_t           w0, w1, w2, w3;

    // Two-flop synchroniser plus one more flop for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_prev <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_prev <= echo_s;
        end
    end

    assign rise        = echo_s & ~echo_prev;
    assign fall        = ~echo_s & echo_prev;
    assign presc_wrap  = (presc == PRESC_LAST);
    assign period_done = (period_cnt >= PERIOD_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        work_clear = 1'b0;
        work_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) next_state = TRIG;
            end
            TRIG: begin
                if (phase_cnt == TRIG_LAST) next_state = WAIT_RISE;
            end
            WAIT_RISE: begin
                // Only a genuine rising edge starts a measurement; an echo
                // already high when the trigger ends is left to time out.
                if (rise) begin
                    next_state = MEASURE;
                    work_clear = 1'b1;
                end else if (phase_cnt == WAIT_LAST) begin
                    next_state = DONE_BAD;
                end
            end
            MEASURE: begin
                // The fall cycle itself is still counted so that the reading
                // covers the full synchronised high time.
                if (presc_wrap && work_exceeds) begin
                    next_state = DONE_BAD;
                end else begin
                    work_inc = presc_wrap;
                    if (fall) next_state = DONE_OK;
                end
            end
            DONE_OK, DONE_BAD: begin
                next_state = HOLD;
            end
            HOLD: begin
                // After a bad reading the echo may still be high; a new
                // trigger is held off until the line is quiet.
                if (period_done && (!no_echo || !echo_s))
                    next_state = enable ? TRIG : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Shared phase counter: trigger width in TRIG, timeout in WAIT_RISE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_cnt <= '0;
        end else if ((next_state != state) || !((state == TRIG) || (state == WAIT_RISE))) begin
            phase_cnt <= '0;
        end else begin
            phase_cnt <= phase_cnt + PHW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (work_clear) begin
            presc <= '0;
        end else if (state == MEASURE) begin
            presc <= presc_wrap ? '0 : presc + PRW'(1);
        end
    end

    // Period counter restarts on every trigger rise and saturates so that a
    // long HOLD (waiting for the echo to drop) cannot wrap it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            period_cnt <= '0;
        end else if ((next_state == TRIG) && (state != TRIG)) begin
            period_cnt <= '0;
        end else if (period_cnt != PERIOD_SAT) begin
            period_cnt <= period_cnt + PDW'(1);
        end
    end

    bcd_counter4 #(
        .MAX_CM(MAX_CM)
    ) u_work (
        .clk         (clk),
        .reset       (reset),
        .clear       (work_clear),
        .inc         (work_inc),
        .d0          (w0),
        .d1          (w1),
        .d2          (w2),
        .d3          (w3),
        .next_exceeds(work_exceeds)
    );

    // Registered outputs. trig and busy are decoded from next_state so they
    // line up exactly with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig    <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            no_echo <= 1'b0;
            digit0  <= '0;
            digit1  <= '0;
            digit2  <= '0;
            digit3  <= '0;
        end else begin
            trig  <= (next_state == TRIG);
            busy  <= (next_state != IDLE);
            valid <= (state == DONE_OK) || (state == DONE_BAD);
            if (state == DONE_OK) begin
                digit0  <= w0;
                digit1  <= w1;
                digit2  <= w2;
                digit3  <= w3;
                no_echo <= 1'b0;
            end else if (state == DONE_BAD) begin
                digit0  <= BCD_SAT;
                digit1  <= BCD_SAT;
                digit2  <= BCD_SAT;
                digit3  <= BCD_SAT;
                no_echo <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_echo_ranger.sv
// tb_echo_ranger: self-checking bench for echo_ranger with reduced timing
// parameters. Results are predicted from the echo width in cycles with plain
// integer arithmetic (width / cycles-per-cm, saturating to 9999).
module tb_echo_ranger;
    import ranger_pkg::*;

    localparam int TRIG_CYCLES   = 5;
    localparam int CYCLES_PER_CM = 4;
    localparam int MAX_CM        = 400;
    localparam int WAIT_TIMEOUT  = 200;
    localparam int PERIOD_CYCLES = 2500;

    logic   clk = 1'b0;
    logic   reset, enable, echo;
    logic   trig, valid, no_echo, busy;
    bcd_t   digit0, digit1, digit2, digit3;
    state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int trig_rises = 0;
    int last_rise = 0;
    int prev_rise = 0;
    int fall_cyc = 0;
    int valid_cyc = 0;
    int results = 0;
    int pushes = 0;
    logic trig_d = 1'b0;
    logic valid_d = 1'b0;
    logic [16:0] held = '0;
    logic [16:0] exp_q[$];

    echo_ranger #(
        .TRIG_CYCLES  (TRIG_CYCLES),
        .CYCLES_PER_CM(CYCLES_PER_CM),
        .MAX_CM       (MAX_CM),
        .WAIT_TIMEOUT (WAIT_TIMEOUT),
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .echo     (echo),
        .trig     (trig),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .valid    (valid),
        .no_echo  (no_echo),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: whole centimetres of echo, 9999 with no_echo for no pulse or
    // a distance beyond MAX_CM.
    function automatic logic [16:0] ref_result(input int n);
        int cm;
        cm = n / CYCLES_PER_CM;
        if (n == 0 || cm > MAX_CM) return {1'b1, 16'h9999};
        return {1'b0, 4'((cm / 1000) % 10), 4'((cm / 100) % 10),
                4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [16:0] got, exp;
        if (!reset) begin
            trig_d  = 1'b0;
            valid_d = 1'b0;
            held    = '0;
        end else begin
            got = {no_echo, digit3, digit2, digit1, digit0};
            if (trig && !trig_d) begin
                prev_rise = last_rise;
                last_rise = cyc;
                trig_rises++;
            end
            if (!trig && trig_d) begin
                fall_cyc = cyc;
                check("trig_width", 32'(cyc - last_rise), 32'(TRIG_CYCLES));
            end
            if (valid) begin
                check("valid_one_cycle", 32'(valid_d), 32'(0));
                check("valid_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    exp = exp_q.pop_front();
                    check("result", 32'(got), 32'(exp));
                end
                held      = got;
                valid_cyc = cyc;
                results++;
            end else begin
                check("digits_hold", 32'(got), 32'(held));
            end
            trig_d  = trig;
            valid_d = valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_rise(input int limit);
        int start;
        int k;
        start = trig_rises;
        k = 0;
        while (trig_rises == start && k < limit) begin
            tick();
            k++;
        end
        check("trig_rise_seen", 32'(trig_rises != start), 32'(1));
    endtask

    task automatic wait_fall(input int limit);
        int k;
        k = 0;
        while (trig && k < limit) begin
            tick();
            k++;
        end
        check("trig_fall_seen", 32'(trig), 32'(0));
    endtask

    task automatic wait_empty(input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            tick();
            k++;
        end
        check("result_arrived", 32'(exp_q.size() == 0), 32'(1));
        exp_q.delete();
    endtask

    // Entered while trig is high. Drives one echo of n cycles (n = 0: none)
    // after `delay` cycles, waits for the result, then for the next trigger.
    task automatic do_meas(input int delay, input int n);
        int lat;
        wait_fall(20);
        repeat (delay) tick();
        exp_q.push_back(ref_result(n));
        pushes++;
        if (n > 0) begin
            echo = 1'b1;
            repeat (n) tick();
            echo = 1'b0;
        end
        wait_empty(3000);
        if (n == 0) begin
            lat = valid_cyc - fall_cyc;
            check("timeout_latency", 32'(lat >= WAIT_TIMEOUT && lat <= WAIT_TIMEOUT + 2), 32'(1));
        end
        wait_rise(3000);
        check("period", 32'(last_rise - prev_rise), 32'(PERIOD_CYCLES));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int start;
        int drop;
        int d;
        int n;
        int dir_n[5] = '{3, 796, 800, 1603, 1604};

        reset  = 1'b0;
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) tick();
        check("rst_trig",    32'(trig),      32'(0));
        check("rst_digits",  32'({digit3, digit2, digit1, digit0}), 32'(0));
        check("rst_valid",   32'(valid),     32'(0));
        check("rst_no_echo", 32'(no_echo),   32'(0));
        check("rst_busy",    32'(busy),      32'(0));
        check("rst_state",   32'(dbg_state), 32'(IDLE));

        reset = 1'b1;
        repeat (10) tick();
        check("idle_busy",     32'(busy),       32'(0));
        check("idle_no_trig",  32'(trig_rises), 32'(0));

        enable = 1'b1;
        wait_rise(5);
        check("first_trig_high", 32'(trig), 32'(1));
        check("first_busy",      32'(busy), 32'(1));
        check("first_digits",    32'({digit3, digit2, digit1, digit0}), 32'(0));

        do_meas(20, 492);
        foreach (dir_n[i]) do_meas(7, dir_n[i]);
        for (int i = 0; i < 5; i++) begin
            d = $urandom_range(0, 150);
            n = $urandom_range(1, 1700);
            do_meas(d, n);
        end
        do_meas(0, 0);
        do_meas(10, 2000);

        // Echo already high when the trigger ends: ignored, times out, and
        // the next trigger waits for the echo to drop.
        start = trig_rises;
        echo = 1'b1;
        exp_q.push_back(ref_result(0));
        pushes++;
        repeat (3000) tick();
        check("no_trig_while_echo_high", 32'(trig_rises), 32'(start));
        check("stuck_echo_result", 32'(exp_q.size() == 0), 32'(1));
        echo = 1'b0;
        drop = cyc;
        wait_rise(20);
        check("retrig_after_echo_drop", 32'(last_rise - drop >= 1 && last_rise - drop <= 6), 32'(1));

        // enable dropped mid-measurement: result completes, no new trigger.
        wait_fall(20);
        repeat (5) tick();
        exp_q.push_back(ref_result(400));
        pushes++;
        echo = 1'b1;
        repeat (200) tick();
        enable = 1'b0;
        repeat (200) tick();
        echo = 1'b0;
        wait_empty(100);
        start = trig_rises;
        repeat (3000) tick();
        check("no_trig_after_disable", 32'(trig_rises), 32'(start));
        check("disable_busy",  32'(busy),      32'(0));
        check("disable_state", 32'(dbg_state), 32'(IDLE));

        // Reset pulsed mid-measurement clears outputs immediately.
        enable = 1'b1;
        wait_rise(10);
        wait_fall(20);
        repeat (3) tick();
        echo = 1'b1;
        repeat (100) tick();
        check("pre_reset_state", 32'(dbg_state), 32'(MEASURE));
        reset = 1'b0;
        #1;
        check("async_rst_trig",   32'(trig),  32'(0));
        check("async_rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'(0));
        check("async_rst_valid",  32'(valid), 32'(0));
        check("async_rst_busy",   32'(busy),  32'(0));
        enable = 1'b0;
        echo   = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        start = trig_rises;
        repeat (50) tick();
        check("post_reset_idle_trig",  32'(trig_rises), 32'(start));
        check("post_reset_idle_state", 32'(dbg_state),  32'(IDLE));

        check("all_results_seen", 32'(results), 32'(pushes));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
